uart_loop_fifo: RTL
===================

Name: uart_loop_fifo

Overview:
Elastic byte buffer between the UART receiver and UART transmitter in the loopback path.
- Captures every received byte (single-cycle valid strobe) into a circular FIFO.
- Drains the FIFO to the transmitter one byte per frame, using its request/busy/done handshake.
- Absorbs back-to-back RX bytes that arrive while TX is still shifting, and reports overflow and TX stall conditions.

Parameters:
DATA_W, 8, byte width of each FIFO entry
DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16)
DONE_TIMEOUT, 65535, cycles to wait for tx_done after a request; 0 disables the timeout

Ports:
sysclk  in  1  system clock, all logic on rising edge
rstn  in  1  synchronous active-low reset
in_data  in  DATA_W  received byte from UART RX
in_valid  in  1  one-cycle strobe, in_data valid
tx_data  out  DATA_W  byte presented to UART TX
tx_req  out  1  one-cycle transmit request strobe
tx_busy  in  1  UART TX shifting a frame
tx_done  in  1  one-cycle strobe, TX frame (stop bit) complete
fifo_count  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
fifo_full  out  1  fifo_count == depth
fifo_empty  out  1  fifo_count == 0
ovf_flag  out  1  sticky: a byte was dropped because the FIFO was full
tmo_flag  out  1  sticky: tx_done was not seen within DONE_TIMEOUT
flag_clr  in  1  one-cycle strobe, clears ovf_flag and tmo_flag

Behaviour:
- Reset (rstn low at a rising edge):
  - wr_ptr, rd_ptr, fifo_count cleared to 0.
  - FSM goes to IDLE; timeout counter cleared.
  - tx_req=0, tx_data=0, ovf_flag=0, tmo_flag=0; fifo_empty=1, fifo_full=0.
  - Memory contents are not cleared.
  - Reset mid-frame abandons the wait; any byte already requested is not re-sent.
- Write:
  - At an edge where in_valid=1 and fifo_count<depth (pre-edge value), mem[wr_ptr]<=in_data and wr_ptr increments.
  - If fifo_count==depth, the byte is dropped and ovf_flag<=1. This holds even if a pop happens in the same cycle.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth.
- Count update per edge:
  - fifo_count +1 on write only.
  - -1 on pop only.
  - Unchanged on simultaneous write and pop.
- Status: fifo_full and fifo_empty are decoded combinationally from the registered fifo_count.
- FSM states: IDLE, WAIT_DONE.
  - IDLE: if fifo_count!=0 and tx_busy=0 (pre-edge), then at the edge:
    - tx_data<=mem[rd_ptr]
    - tx_req<=1
    - rd_ptr increments, count decrements (pop)
    - timeout counter<=0
    - go to WAIT_DONE
  - WAIT_DONE:
    - tx_req<=0 (request is exactly one cycle).
    - On tx_done=1, go to IDLE.
    - Otherwise the counter increments. If DONE_TIMEOUT!=0 and the counter reaches DONE_TIMEOUT-1, set tmo_flag<=1 and go to IDLE.
    - tx_done in IDLE is ignored.
- tx_data holds its value until the next request.
- Latency: with the FIFO empty and TX idle, in_valid sampled at edge N gives tx_req high during the cycle after edge N+1 (2 edges).
- Minimum spacing: consecutive tx_req strobes are at least 2 cycles apart after tx_done (tx_done edge -> IDLE, next edge -> request).
- Flags:
  - flag_clr=1 clears both flags at the edge.
  - If a set condition occurs in the same cycle, set wins.
- tx_busy high while in IDLE blocks requests indefinitely; no timeout applies in IDLE.
- Occupancy never exceeds depth, and no underflow is possible: a pop requires count!=0.

Test Plan:
- Single byte: reset, in_valid with 0xA5 at edge N, TX idle.
  -> tx_req one cycle after edge N+1 with tx_data=0xA5; fifo_count 1 then 0; pulse tx_done -> FSM back to IDLE.
- Burst: 5 back-to-back in_valid bytes 0x01..0x05 while the first frame is busy, tx_done pulsed 20 cycles after each request.
  -> tx_req 5 times with data 0x01..0x05 in order; fifo_count peaks at 4; ovf_flag=0.
- Overflow: hold tx_busy=1 and write 17 bytes 0x10..0x20 (DEPTH_LOG2=4).
  -> fifo_full=1, fifo_count=16, ovf_flag=1, byte 0x20 dropped.
  -> Release tx_busy and pulse tx_done per request: sent bytes are 0x10..0x1F.
- Simultaneous write/pop and wrap: stream 40 bytes at 1 byte per 3 cycles, tx_done returned 1 cycle after each request.
  -> all 40 bytes out in order; pointers wrap twice; count never exceeds 2.
- Timeout: DONE_TIMEOUT=8, one byte, tx_done never pulsed.
  -> tmo_flag=1 and state IDLE 8 cycles after tx_req.
  -> flag_clr pulse -> tmo_flag=0 next cycle.
- Reset mid-operation: 3 bytes queued, in WAIT_DONE, assert rstn=0 for one edge.
  -> fifo_count=0, fifo_empty=1, tx_req=0, tx_data=0, flags 0; no further tx_req without new input.

Source files
------------

// File: rtl/uart_loop_fifo.sv
// Elastic byte FIFO between the UART receiver and transmitter in the loopback path.
// It captures strobed RX bytes and releases them one frame at a time using the TX request/done handshake.
module uart_loop_fifo #(
  parameter int DATA_W       = 8,
  parameter int DEPTH_LOG2   = 4,
  parameter int DONE_TIMEOUT = 65535
) (
  input  logic                  sysclk,
  input  logic                  rstn,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  tx_req,
  input  logic                  tx_busy,
  input  logic                  tx_done,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  ovf_flag,
  output logic                  tmo_flag,
  input  logic                  flag_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TMO_W = (DONE_TIMEOUT >= 2) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(DONE_TIMEOUT - 1);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {IDLE, WAIT_DONE} state_t;

  state_t                state, next_state;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  wr_en, ovf_set, pop, tmo_set;

  assign fifo_full  = (fifo_count == DEPTH_CNT);
  assign fifo_empty = (fifo_count == '0);
  // A byte arriving while full is lost even if a pop frees a slot on the same edge.
  assign wr_en      = in_valid && !fifo_full;
  assign ovf_set    = in_valid && fifo_full;

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    tmo_set    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          pop        = 1'b1;
          next_state = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          next_state = IDLE;
        end else if ((DONE_TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
          tmo_set    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge sysclk) begin
    if (rstn && wr_en) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge sysclk) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tx_req     <= 1'b0;
      tx_data    <= '0;
      tmo_cnt    <= '0;
      ovf_flag   <= 1'b0;
      tmo_flag   <= 1'b0;
    end else begin
      tx_req <= pop;
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (pop)                     tmo_cnt <= '0;
      else if (state == WAIT_DONE) tmo_cnt <= tmo_cnt + 1'b1;
      if (ovf_set)       ovf_flag <= 1'b1;
      else if (flag_clr) ovf_flag <= 1'b0;
      if (tmo_set)       tmo_flag <= 1'b1;
      else if (flag_clr) tmo_flag <= 1'b0;
    end
  end

endmodule
